instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator for the read-only instruction memory port (m_cs/m_rd/Addr/D_Out).
//  Sequences word addresses from a fetch PC and drives the memory read strobes.
//  Buffers returned words with their PCs in a small prefetch FIFO.
//  Hands {pc, instr} to decode over a valid/ready handshake; supports branch redirect.
// PARAMETERS
//  FIFO_DEPTH  4       prefetch entries; power of 2, >= 2
//  RESET_PC    32'h0   first fetch address after reset; word-aligned
//  MEM_BYTES   4096    instruction memory size in bytes; fetch PC wraps inside it
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  fetch_en     in   1   1 = issue new memory reads; 0 = stop issuing, FIFO still drains
//  redirect     in   1   1 = flush FIFO and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored (forced to 0)
//  m_cs         out  1   memory chip select
//  m_rd         out  1   memory read strobe (always equal to m_cs)
//  m_addr       out  32  byte address of the big-endian word being read
//  m_din        in   32  memory read data; valid in the same cycle as m_cs&m_rd
//  ir_valid     out  1   FIFO head holds a valid instruction
//  ir_ready     in   1   decode accepts head this cycle when ir_valid=1
//  ir_out       out  32  head instruction word; 0 when ir_valid=0
//  pc_out       out  32  byte address of ir_out; 0 when ir_valid=0
// BEHAVIOUR
//  Interface:
//  - Clock and reset: one clock, clk. Reset is synchronous and active-high.
//  - Reset: fetch_pc=RESET_PC, count=0. Outputs ir_valid=0, ir_out=0, pc_out=0, m_cs=m_rd=0.
//  - m_addr always equals fetch_pc.
//  Read issue:
//  - Define pop = ir_valid & ir_ready.
//  - issue = fetch_en & ~redirect & ~reset & (count<FIFO_DEPTH | pop).
//  - m_cs = m_rd = issue, combinational. This gives a same-cycle path from ir_ready.
//  - On posedge with issue=1: push {fetch_pc, m_din} and advance fetch_pc.
//  - PC advance: fetch_pc += 4. fetch_pc = MEM_BYTES-4 wraps to 0. No m_addr+3 ever exceeds MEM_BYTES-1.
//  Handshake and latency:
//  - ir_valid = (count!=0). Head fields come straight from FIFO registers, with no extra stage.
//  - Read issued in cycle n: word is visible at ir_out in cycle n+1, at the earliest.
//  - Steady state with ir_ready=1 and fetch_en=1: one instruction per cycle.
//  - Order is strict. pc_out of consecutive pops differs by 4, except after a wrap or a redirect.
//  Count rules:
//  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged.
//  - Push and pop together is legal at full and at count=1.
//  - Pop is never permitted when empty, since ir_valid=0.
//  Redirect (priority over everything except reset):
//  - The posedge after redirect=1: count=0, fetch_pc = {redirect_pc[31:2], 2'b00}.
//  - No read is issued in the redirect cycle.
//  - A pop in the redirect cycle still completes, i.e. decode consumed the head. All other entries are discarded.
//  - Cycle n redirect: cycle n+1 reads redirect_pc; cycle n+2 ir_valid=1 with pc_out=redirect_pc.
//  - Back-to-back redirects: the last one wins.
//  fetch_en=0:
//  - fetch_pc holds and no read is issued. Existing entries remain poppable.
//  - Redirect still applies.
//  Reset mid-operation:
//  - Reset overrides redirect, push and pop.
//  - The FIFO empties and fetch_pc returns to RESET_PC on that posedge.
//  FSM (2-bit): the FSM is observable only through m_cs and ir_valid.
//  - S_FETCH: issuing. Go to S_FULL when count reaches DEPTH with no pop.
//  - S_FULL: no issue. Go back to S_FETCH on pop.
//  - S_HALT: entered when fetch_en=0. Go back to S_FETCH when fetch_en=1.
//  - S_FLUSH: the single redirect cycle. Then go to S_FETCH, or to S_HALT if fetch_en=0.
// STRUCTURE
//  - fetch_defs.vh holds the constants and state codes shared with decode and testbenches:
//    WORD_BYTES=4, PC_STEP=4, S_FETCH/S_FULL/S_HALT/S_FLUSH.
//  - Sub-module fetch_fifo: synchronous FIFO, width 64 = {pc,instr}, depth FIFO_DEPTH.
//  - fetch_fifo ports: push, pop, flush, head data, count.
//  - The top level holds the FSM, fetch_pc, the wrap logic and the issue logic.
// TESTING
//  - Reset then fetch_en=1, ir_ready=1, memory words w0..w7 at 0x0..0x1C:
//    ir_valid=1 from cycle 2; pc_out 0,4,8,... each cycle with matching data.
//  - ir_ready=0 for 10 cycles: exactly 4 reads are issued (m_cs high 4 cycles), count=4, then m_cs=0.
//    Raising ir_ready: pop and push together, PCs continuous, none lost or duplicated.
//  - Redirect with redirect_pc=0x103 while FIFO has 3 entries:
//    next posedge count=0, m_addr=0x100; two cycles later pc_out=0x100.
//  - fetch_pc=MEM_BYTES-4 (0xFFC) fetched, then next m_addr=0x000; pc_out sequence 0xFFC, 0x000.
//  - fetch_en=0 with 2 entries: m_cs stays 0, both entries pop intact, then ir_valid=0 and ir_out=0.
//  - reset asserted mid-stream with redirect=1 in the same cycle:
//    next cycle count=0, m_addr=RESET_PC, ir_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch path: word geometry, FSM state codes
// and the wrapping PC-advance helper.
package instr_fetch_unit_pkg;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] PC_STEP    = 32'(WORD_BYTES);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // The last word of memory wraps to 0, so m_addr+3 never leaves the array.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc,
                                                input logic [31:0] mem_bytes);
    logic [31:0] nxt;
    if (pc >= (mem_bytes - PC_STEP)) begin
      nxt = 32'd0;
    end else begin
      nxt = pc + PC_STEP;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; the head is read straight from the storage
// registers. flush empties it, and reset takes priority over flush, push and pop.
module instr_fetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage write; entries need no reset because count gates their visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: sequences word reads from fetch_pc, buffers them with
// their PCs and hands {pc, instr} to decode over valid/ready, with branch redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          MEM_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        m_cs,
  output logic        m_rd,
  output logic [31:0] m_addr,
  input  logic [31:0] m_din,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out
);

  localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      MEM_BYTES_C = 32'(MEM_BYTES);

  logic [31:0]      fetch_pc_r;
  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] count_s;
  logic [63:0]      head_s;
  logic             pop_s;
  logic             issue_s;

  assign pop_s   = ir_valid & ir_ready;
  // A same-cycle pop frees a slot, so a full FIFO can still accept a read.
  assign issue_s = fetch_en & ~redirect & ~reset & ((count_s < DEPTH_C) | pop_s);

  assign m_cs     = issue_s;
  assign m_rd     = issue_s;
  assign m_addr   = fetch_pc_r;
  assign ir_valid = (count_s != {CNT_W{1'b0}});
  assign ir_out   = ir_valid ? head_s[31:0]  : 32'd0;
  assign pc_out   = ir_valid ? head_s[63:32] : 32'd0;

  instr_fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   ({fetch_pc_r, m_din}),
    .head  (head_s),
    .count (count_s)
  );

  // Fetch FSM next state; redirect always lands in the single flush cycle.
  always_comb begin
    state_s = state_r;
    if (redirect) begin
      state_s = S_FLUSH;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (!fetch_en) begin
            state_s = S_HALT;
          end else if (issue_s && !pop_s && (count_s == DEPTH_M1_C)) begin
            state_s = S_FULL;
          end else begin
            state_s = S_FETCH;
          end
        end
        S_FULL: begin
          if (!fetch_en) begin
            state_s = S_HALT;
          end else if (pop_s) begin
            state_s = S_FETCH;
          end else begin
            state_s = S_FULL;
          end
        end
        S_HALT: begin
          if (fetch_en) begin
            state_s = S_FETCH;
          end else begin
            state_s = S_HALT;
          end
        end
        S_FLUSH: begin
          if (fetch_en) begin
            state_s = S_FETCH;
          end else begin
            state_s = S_HALT;
          end
        end
        default: state_s = S_FETCH;
      endcase
    end
  end

  // Fetch PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      state_r    <= S_FETCH;
    end else begin
      state_r <= state_s;
      if (redirect) begin
        fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      end else if (issue_s) begin
        fetch_pc_r <= next_fetch_pc(fetch_pc_r, MEM_BYTES_C);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

endmodule
